// File: rtl/dp_pkg.sv
// Shared constants and types for the accumulator CPU datapath: default widths,
// accumulator source encodings, opcodes and the ALU overflow helper.
package dp_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    STORE = 3'b001,
    ADD   = 3'b010,
    SUB   = 3'b011,
    IN    = 3'b100,
    JZ    = 3'b101,
    JPOS  = 3'b110,
    HALT  = 3'b111
  } opcode_e;

  // Signed overflow from sign bits: operands agree (add) or differ (sub) and result flips.
  function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic sub);
    return (sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Control-unit <-> datapath bundle. Ovf only exists when DP_OVF_FLAG_EN is defined.
interface cpu_datapath_if #(
  parameter int DATA_W = dp_pkg::DATA_W,
  parameter int ADDR_W = dp_pkg::ADDR_W
);
  logic              IRload;
  logic              PCload;
  logic              JMPmux;
  logic              Meminst;
  logic              MemWr;
  logic              Aload;
  logic              Sub;
  logic [1:0]        Asel;
  logic [DATA_W-1:0] Input;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic [2:0]        IR;
  logic              Aeq0;
  logic              Apos;
  logic [DATA_W-1:0] Output;
  logic [ADDR_W-1:0] PCout;
`ifdef DP_OVF_FLAG_EN
  logic              Ovf;
`endif

  modport master (
    output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Input,
           LoadEn, LoadAddr, LoadData,
`ifdef DP_OVF_FLAG_EN
    input  Ovf,
`endif
    input  IR, Aeq0, Apos, Output, PCout
  );

  modport slave (
    input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Input,
           LoadEn, LoadAddr, LoadData,
`ifdef DP_OVF_FLAG_EN
    output Ovf,
`endif
    output IR, Aeq0, Apos, Output, PCout
  );
endinterface

// File: rtl/dp_ram.sv
// Program/data RAM: one write port shared by program load (priority) and STORE,
// synchronous read with read-before-write; only the read register is reset.
module dp_ram #(
  parameter int DATA_W = dp_pkg::DATA_W,
  parameter int ADDR_W = dp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we      = load_en | wr_en;
    waddr   = load_en ? load_addr : addr;
    wdata   = load_en ? load_data : wr_data;
    rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, accumulator A and RAM. Define DP_OVF_FLAG_EN
// to add the sticky signed-overflow flag Ovf.
module cpu_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W = dp_pkg::DATA_W,
  parameter int ADDR_W = dp_pkg::ADDR_W
) (
  input  logic           Clock,
  input  logic           Reset,
  cpu_datapath_if.slave  bus
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] mem_addr;

  dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (Clock),
    .rst       (Reset),
    .addr      (mem_addr),
    .wr_en     (bus.MemWr),
    .wr_data   (a_q),
    .load_en   (bus.LoadEn),
    .load_addr (bus.LoadAddr),
    .load_data (bus.LoadData),
    .rdata     (mdata)
  );

  always_comb begin
    mem_addr = bus.Meminst ? ir_q[ADDR_W-1:0] : pc_q;
    alu_res  = bus.Sub ? a_q - mdata : a_q + mdata;
    ir_d     = bus.IRload ? mdata : ir_q;
    pc_d     = pc_q;
    if (bus.PCload) pc_d = bus.JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    a_d = a_q;
    if (bus.Aload) begin
      case (asel_e'(bus.Asel))
        ASEL_ALU:  a_d = alu_res;
        ASEL_IN:   a_d = bus.Input;
        ASEL_MEM:  a_d = mdata;
        default:   a_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
    end
  end

`ifdef DP_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.Aload && (asel_e'(bus.Asel) == ASEL_ALU) &&
        add_sub_ovf(a_q[DATA_W-1], mdata[DATA_W-1], alu_res[DATA_W-1], bus.Sub))
      ovf_d = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.Ovf = ovf_q;
`endif

  // Status outputs come from registers only, so no strobe-to-output paths exist.
  assign bus.IR     = ir_q[DATA_W-1 -: 3];
  assign bus.Aeq0   = (a_q == '0);
  assign bus.Apos   = ~a_q[DATA_W-1];
  assign bus.Output = a_q;
  assign bus.PCout  = pc_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios then random cycles
// against a cycle-level behavioural model of the datapath.
module tb_cpu_datapath;
  import dp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cpu_datapath_if bus_if ();

  cpu_datapath dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  logic [7:0] m_mem [32];
  logic [7:0] m_a, m_ir, m_md;
  logic [4:0] m_pc;
`ifdef DP_OVF_FLAG_EN
  logic       m_ovf;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_IR"},     32'(bus_if.IR),     32'(m_ir[7:5]));
    chk({tag, "_Aeq0"},   32'(bus_if.Aeq0),   32'(m_a == 8'd0));
    chk({tag, "_Apos"},   32'(bus_if.Apos),   32'(int'($signed(m_a)) >= 0));
    chk({tag, "_Output"}, 32'(bus_if.Output), 32'(m_a));
    chk({tag, "_PCout"},  32'(bus_if.PCout),  32'(m_pc));
`ifdef DP_OVF_FLAG_EN
    chk({tag, "_Ovf"},    32'(bus_if.Ovf),    32'(m_ovf));
`endif
  endtask

  task automatic drive_idle();
    bus_if.IRload = 0; bus_if.PCload = 0; bus_if.JMPmux = 0; bus_if.Meminst = 0;
    bus_if.MemWr = 0;  bus_if.Aload = 0;  bus_if.Sub = 0;    bus_if.Asel = 2'b00;
    bus_if.Input = 0;  bus_if.LoadEn = 0; bus_if.LoadAddr = 0; bus_if.LoadData = 0;
  endtask

  // One clock cycle: drive strobes, advance the model, sample on the falling edge.
  task automatic cycle(input string tag, input logic irl, input logic pcl, input logic jmp,
                       input logic mi, input logic mw, input logic al, input logic sb,
                       input logic [1:0] as, input logic [7:0] inp,
                       input logic le, input logic [4:0] la, input logic [7:0] ld);
    int         addr;
    int         res;
    logic [7:0] old_a, old_md, old_ir;
    bus_if.IRload = irl; bus_if.PCload = pcl; bus_if.JMPmux = jmp; bus_if.Meminst = mi;
    bus_if.MemWr = mw;   bus_if.Aload = al;   bus_if.Sub = sb;     bus_if.Asel = as;
    bus_if.Input = inp;  bus_if.LoadEn = le;  bus_if.LoadAddr = la; bus_if.LoadData = ld;
    old_a = m_a; old_md = m_md; old_ir = m_ir;
    addr = mi ? int'(old_ir[4:0]) : int'(m_pc);
    m_md = m_mem[addr];
    if (le)      m_mem[la]   = ld;
    else if (mw) m_mem[addr] = old_a;
    if (irl) m_ir = old_md;
    if (pcl) m_pc = jmp ? old_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
    if (al) begin
      case (as)
        2'd0: begin
          res = sb ? int'($signed(old_a)) - int'($signed(old_md))
                   : int'($signed(old_a)) + int'($signed(old_md));
`ifdef DP_OVF_FLAG_EN
          if (res > 127 || res < -128) m_ovf = 1'b1;
`endif
          m_a = 8'(res);
        end
        2'd1: m_a = inp;
        2'd2: m_a = old_md;
        default: m_a = 8'd0;
      endcase
    end
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    $display("[TB] %s ctl=%b%b%b%b%b%b%b asel=%0d le=%b A=%02h PC=%0d IR=%b", tag,
             irl, pcl, jmp, mi, mw, al, sb, as, le, bus_if.Output, bus_if.PCout, bus_if.IR);
    check_model(tag);
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    cycle("load", 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 1, a, d);
  endtask

  task automatic set_ir(input logic [7:0] v);
    load(m_pc, v);
    cycle("fetch", 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("irload", 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
  endtask

  task automatic reset_model();
    m_a = 0; m_ir = 0; m_md = 0; m_pc = 0;
`ifdef DP_OVF_FLAG_EN
    m_ovf = 0;
`endif
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    reset_model();
    #1;
    check_model(tag);
    chk({tag, "_Out0"}, 32'(bus_if.Output), 32'h0);
    chk({tag, "_PC0"},  32'(bus_if.PCout),  32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    reset_model();
    @(negedge clk);
    async_reset("rst0");
    chk("rst0_Aeq0", 32'(bus_if.Aeq0), 32'h1);
    chk("rst0_Apos", 32'(bus_if.Apos), 32'h1);

    for (int i = 0; i < 32; i++) load(5'(i), 8'($urandom));

    // Fetch LOAD 31, then load A from memory.
    load(5'd0, 8'h1F);
    load(5'd31, 8'h05);
    cycle("r26_rd", 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r26_ir", 1, 1, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r26_IR", 32'(bus_if.IR), 32'h0);
    chk("r26_PC", 32'(bus_if.PCout), 32'd1);
    cycle("r26_mi", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r26_al", 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'h00, 0, 5'd0, 8'h00);
    chk("r26_A", 32'(bus_if.Output), 32'h05);
    chk("r26_Apos", 32'(bus_if.Apos), 32'h1);
    chk("r26_Aeq0", 32'(bus_if.Aeq0), 32'h0);

    // Subtract 7 then add 2 back to zero.
    load(5'd1, 8'h0A);
    load(5'd10, 8'h07);
    cycle("r27_rd", 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r27_ir", 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r27_mi", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r27_sub", 0, 0, 0, 1, 0, 1, 1, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r27_A_sub", 32'(bus_if.Output), 32'hFE);
    chk("r27_Apos", 32'(bus_if.Apos), 32'h0);
    load(5'd10, 8'h02);
    cycle("r27_mi2", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r27_add", 0, 0, 0, 0, 0, 1, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r27_A_add", 32'(bus_if.Output), 32'h00);
    chk("r27_Aeq0", 32'(bus_if.Aeq0), 32'h1);

    // PC wrap and jump.
    set_ir(8'h1F);
    cycle("r28_j31", 0, 1, 1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r28_PC31", 32'(bus_if.PCout), 32'd31);
    cycle("r28_wrap", 0, 1, 0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r28_wrap", 32'(bus_if.PCout), 32'd0);
    set_ir(8'hB4);
    cycle("r28_jmp", 0, 1, 1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r28_PC20", 32'(bus_if.PCout), 32'd20);
    chk("r28_IR", 32'(bus_if.IR), 32'h5);

    // STORE, then program load overriding a same-cycle store.
    cycle("r29_in", 0, 0, 0, 0, 0, 1, 0, 2'd1, 8'h3C, 0, 5'd0, 8'h00);
    set_ir(8'h2A);
    cycle("r29_st", 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r29_rd", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r29_al", 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'h00, 0, 5'd0, 8'h00);
    chk("r29_store", 32'(bus_if.Output), 32'h3C);
    cycle("r29_pri", 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'h00, 1, 5'd10, 8'h99);
    cycle("r29_rd2", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r29_al2", 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'h00, 0, 5'd0, 8'h00);
    chk("r29_loadpri", 32'(bus_if.Output), 32'h99);

    // Reset mid-program keeps memory.
    cycle("r30_in", 0, 0, 0, 0, 0, 1, 0, 2'd1, 8'h42, 0, 5'd0, 8'h00);
    set_ir(8'h07);
    cycle("r30_jmp", 0, 1, 1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r30_PC7", 32'(bus_if.PCout), 32'd7);
    chk("r30_A42", 32'(bus_if.Output), 32'h42);
    async_reset("r30_rst");
    set_ir(8'h0A);
    cycle("r30_rd", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r30_al", 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'h00, 0, 5'd0, 8'h00);
    chk("r30_mem", 32'(bus_if.Output), 32'h99);

`ifdef DP_OVF_FLAG_EN
    cycle("r31_in", 0, 0, 0, 0, 0, 1, 0, 2'd1, 8'h7F, 0, 5'd0, 8'h00);
    load(5'd10, 8'h01);
    cycle("r31_rd", 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    cycle("r31_add", 0, 0, 0, 1, 0, 1, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r31_A80", 32'(bus_if.Output), 32'h80);
    chk("r31_ovf", 32'(bus_if.Ovf), 32'h1);
    cycle("r31_add2", 0, 0, 0, 1, 0, 1, 0, 2'd0, 8'h00, 0, 5'd0, 8'h00);
    chk("r31_A81", 32'(bus_if.Output), 32'h81);
    chk("r31_sticky", 32'(bus_if.Ovf), 32'h1);
    async_reset("r31_rst");
    chk("r31_clr", 32'(bus_if.Ovf), 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0), 5'($urandom), 8'($urandom));
      if (i == 200) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, accumulator/memory word width; ADDR_W, 5, PC/memory address width (depth 2**ADDR_W).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous active-high reset.
REQ-005 IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub  in  1 each  control-unit strobes.
REQ-006 Asel  in  2  accumulator source select.
REQ-007 Input  in  DATA_W  external input word.
REQ-008 LoadEn  in  1  program-load write strobe; LoadAddr  in  ADDR_W; LoadData  in  DATA_W.
REQ-009 IR  out  3  opcode field IRreg[7:5] to control unit.
REQ-010 Aeq0  out  1  A == 0; Apos  out  1  A[DATA_W-1] == 0 (non-negative, includes zero).
REQ-011 Output  out  DATA_W  current accumulator value; PCout  out  ADDR_W  current PC.

Function
REQ-012 Memory address SHALL be IRreg[4:0] when Meminst=1, else PC.
REQ-013 Memory read SHALL be synchronous: Mdata <= Mem[addr] every cycle, one-cycle latency, read-before-write on the same address.
REQ-014 When MemWr=1, Mem[addr] SHALL be written with A at the clock edge.
REQ-015 LoadEn=1 SHALL write LoadData to Mem[LoadAddr] and take priority over MemWr in the same cycle; Mdata read still uses REQ-012 address.
REQ-016 When IRload=1, IRreg (8 bits) SHALL load Mdata.
REQ-017 When PCload=1, PC SHALL load IRreg[4:0] if JMPmux=1, else PC+1 modulo 2**ADDR_W (31 wraps to 0).
REQ-018 When Aload=1, A SHALL load: Asel=00 -> A+Mdata (Sub=0) or A-Mdata (Sub=1), modulo 2**DATA_W; 01 -> Input; 10 -> Mdata; 11 -> 0.
REQ-019 Aeq0, Apos, IR, Output, PCout SHALL be combinational from registers only (no path from strobe inputs).
REQ-020 Simultaneous IRload, PCload, Aload, MemWr SHALL all take effect in the same edge using pre-edge register values.

Reset
REQ-021 Reset SHALL clear PC, IRreg, A, Mdata to 0 immediately (async), giving IR=000, Aeq0=1, Apos=1, Output=0, PCout=0.
REQ-022 Memory contents SHALL NOT be reset; a reset mid-program leaves memory intact and restarts fetch at address 0.

Configuration
REQ-023 Macro DP_OVF_FLAG_EN: when defined, output Ovf (1 bit) SHALL be present, set sticky on any Aload with Asel=00 producing signed two's-complement overflow, cleared only by Reset; when undefined, port and logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 Shared package dp_pkg SHALL hold DATA_W/ADDR_W defaults, Asel encodings (ASEL_ALU, ASEL_IN, ASEL_MEM, ASEL_ZERO), and opcode constants LOAD..HALT (000..111).
REQ-025 Sub-module dp_ram SHALL implement the 2**ADDR_W x DATA_W synchronous-read, single-write-port RAM with load-port priority mux.

Verification
REQ-026 Load Mem[0]=0x1F(load 31), Mem[31]=0x05; pulse Meminst=0 one cycle, then IRload=1 PCload=1 -> IR=000, PC=1; Meminst=1 one cycle, then Aload=1 Asel=10 -> A=0x05, Apos=1, Aeq0=0.
REQ-027 A=0x05, Mem[10]=0x07, Meminst=1 then Aload Asel=00 Sub=1 -> A=0xFE, Apos=0; repeat Sub=0 with Mdata=0x02 -> A=0x00, Aeq0=1.
REQ-028 PC=31, PCload=1 JMPmux=0 -> PC=0; IRreg=0xB4, PCload=1 JMPmux=1 -> PC=20.
REQ-029 A=0x3C, IRreg=0x2A, Meminst=1 MemWr=1 -> next-cycle read of Mem[10] returns 0x3C; same cycle LoadEn to addr 10 with 0x99 -> Mem[10]=0x99.
REQ-030 Assert Reset mid-sequence with A=0x42, PC=7 -> A=0, PC=0 without clock edge; memory contents unchanged on re-read.
REQ-031 With DP_OVF_FLAG_EN: A=0x7F, Mdata=0x01, add -> A=0x80, Ovf=1 and stays 1 after later non-overflowing add; cleared by Reset.
